// File: rtl/wb_mux_pkg.sv
// wb_mux_pkg: shared state encoding, width helper and limits for the Wishbone mux.
package wb_mux_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ERR = 2'd2;
  localparam int MAX_PORTS = 16;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ACTIVE = ST_ACTIVE,
    ERR = ST_ERR
  } state_t;
  // Never returns 0 so single-entry ranges still get a 1-bit register.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: prefix/mask address match across all ports; lowest index wins.
module wb_addr_decode
  import wb_mux_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IW = clog2(PORTS)
) (
  input  logic [ADDR_WIDTH-1:0]       adr_i,
  input  logic [PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [PORTS*ADDR_WIDTH-1:0] msk_i,
  output logic [PORTS-1:0]            match_o,
  output logic                        valid_o,
  output logic [IW-1:0]               idx_o
);
  logic [PORTS-1:0] raw;
  always_comb begin
    raw = '0;
    for (int i = 0; i < PORTS; i++)
      raw[i] = ~|((adr_i ^ addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]) & msk_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
  end
  assign match_o = raw & (~raw + 1'b1);
  assign valid_o = |raw;
  always_comb begin
    idx_o = '0;
    for (int i = PORTS - 1; i >= 0; i--)
      if (raw[i]) idx_o = IW'(i);
  end
endmodule

// File: rtl/wb_mux_n.sv
// wb_mux_n: N-port Wishbone classic mux with registered slave select and decode-error/watchdog termination.
// Define WB_MUX_TIMEOUT_EN to build the bus-timeout watchdog; otherwise timeout_o is tied 0.
module wb_mux_n
  import wb_mux_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]         wbm_dat_i,
  input  logic                          wbm_we_i,
  input  logic [SELECT_WIDTH-1:0]       wbm_sel_i,
  input  logic                          wbm_stb_i,
  input  logic                          wbm_cyc_i,
  output logic [DATA_WIDTH-1:0]         wbm_dat_o,
  output logic                          wbm_ack_o,
  output logic                          wbm_err_o,
  output logic                          wbm_rty_o,
  output logic [PORTS*ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [PORTS*DATA_WIDTH-1:0]   wbs_dat_o,
  output logic [PORTS-1:0]              wbs_we_o,
  output logic [PORTS-1:0]              wbs_stb_o,
  output logic [PORTS-1:0]              wbs_cyc_o,
  output logic [PORTS*SELECT_WIDTH-1:0] wbs_sel_o,
  input  logic [PORTS*DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic [PORTS-1:0]              wbs_ack_i,
  input  logic [PORTS-1:0]              wbs_err_i,
  input  logic [PORTS-1:0]              wbs_rty_i,
  input  logic [PORTS*ADDR_WIDTH-1:0]   wbs_addr,
  input  logic [PORTS*ADDR_WIDTH-1:0]   wbs_addr_msk,
  output logic                          timeout_o
);
  localparam int IW = clog2(PORTS);
  if (PORTS < 1 || PORTS > MAX_PORTS || TIMEOUT < 2 || TIMEOUT > 65536) begin : g_chk
    $error("wb_mux_n: PORTS or TIMEOUT out of range");
  end
  state_t state_q, state_d;
  logic [IW-1:0] sel_q, sel_d, dec_idx;
  logic [PORTS-1:0] dec_hit, sel_oh;
  logic dec_vld, req, active, term, expire, gate;
  wb_addr_decode #(.PORTS(PORTS), .ADDR_WIDTH(ADDR_WIDTH), .IW(IW)) u_dec (
    .adr_i  (wbm_adr_i),
    .addr_i (wbs_addr),
    .msk_i  (wbs_addr_msk),
    .match_o(dec_hit),
    .valid_o(dec_vld),
    .idx_o  (dec_idx)
  );
  assign req = wbm_cyc_i & wbm_stb_i;
  assign active = state_q == ACTIVE;
  assign term = wbs_ack_i[sel_q] | wbs_err_i[sel_q] | wbs_rty_i[sel_q];
  assign sel_oh = PORTS'(1) << sel_q;
`ifdef WB_MUX_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT);
  logic [TW-1:0] tmo_q, tmo_d;
  // Any slave termination in the expiry cycle takes precedence over the watchdog.
  assign expire = active & ~term & (tmo_q == TW'(TIMEOUT - 1));
  assign tmo_d = (active && state_d == ACTIVE) ? tmo_q + 1'b1 : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign expire = 1'b0;
`endif
  assign timeout_o = expire;
  assign gate = active & ~expire;
  assign wbs_cyc_o = (gate & wbm_cyc_i) ? sel_oh : '0;
  assign wbs_stb_o = (gate & wbm_cyc_i & wbm_stb_i) ? sel_oh : '0;
  assign wbs_we_o = (gate & wbm_we_i) ? sel_oh : '0;
  assign wbs_adr_o = {PORTS{wbm_adr_i}};
  assign wbs_dat_o = {PORTS{wbm_dat_i}};
  assign wbs_sel_o = {PORTS{wbm_sel_i}};
  assign wbm_ack_o = active & wbs_ack_i[sel_q];
  assign wbm_rty_o = active & wbs_rty_i[sel_q];
  assign wbm_err_o = (state_q == ERR) | (active & wbs_err_i[sel_q]) | expire;
  assign wbm_dat_o = active ? wbs_dat_i[sel_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = |dec_hit ? ACTIVE : ERR;
        sel_d = dec_vld ? dec_idx : sel_q;
      end
      ACTIVE: if (term || !wbm_cyc_i || expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
    end
endmodule

// File: doc/wb_mux_n.md
# wb_mux_n

Parametrised N-port Wishbone classic multiplexer with registered slave selection and a bus-timeout watchdog. It sits between one Wishbone master and PORTS address-mapped slaves and replaces fixed-port muxes. The slave is chosen once per transfer and held until termination. Unmapped addresses and hung slaves both terminate the transfer with an error instead of stalling the bus.

## Interface
- PORTS, 4: number of slave ports, 1..16
- DATA_WIDTH, 32: data bus width in bits (8/16/32/64)
- ADDR_WIDTH, 32: address bus width in bits
- SELECT_WIDTH, DATA_WIDTH/8: byte-select width
- TIMEOUT, 256: cycles in ACTIVE before watchdog error, 2..65536
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i  in  ADDR/DATA/1/SELECT/1/1  master request
- wbm_dat_o  out  DATA_WIDTH  read data from the selected slave
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  1  master termination
- wbs_adr_o, wbs_dat_o  out  PORTS*ADDR_WIDTH, PORTS*DATA_WIDTH  flattened; slave i at slice i
- wbs_we_o, wbs_stb_o, wbs_cyc_o  out  PORTS  per-slave control
- wbs_sel_o  out  PORTS*SELECT_WIDTH  flattened byte select
- wbs_dat_i  in  PORTS*DATA_WIDTH  flattened slave read data
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  PORTS  per-slave termination
- wbs_addr, wbs_addr_msk  in  PORTS*ADDR_WIDTH  per-slave prefix and mask; match = ~|((adr^addr)&msk)
- timeout_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, ACTIVE, ERR. Registers: state, sel_idx, tmo_cnt.
- IDLE: on wbm_cyc_i & wbm_stb_i, decode all ports. The lowest-index match wins.
  - Match: latch sel_idx and go to ACTIVE.
  - No match: go to ERR.
- ACTIVE: slave sel_idx gets cyc=wbm_cyc_i, stb=wbm_stb_i and we=wbm_we_i. All other slaves' cyc/stb/we are 0.
- In ACTIVE, adr, dat and sel are broadcast to every slave unconditionally.
- wbm_ack_o, wbm_err_o and wbm_rty_o forward only slave sel_idx's terminations. Ack/err/rty from unselected slaves is ignored.
- wbm_dat_o = slave sel_idx's data in ACTIVE. It is zero in IDLE and ERR.
- Any termination in ACTIVE returns to IDLE next cycle.
- Master abort: wbm_cyc_i low in ACTIVE gates the slave strobes immediately and returns to IDLE.
- ERR: wbm_err_o=1 for exactly one cycle, then IDLE.
- Watchdog: tmo_cnt clears on entry to ACTIVE and increments every ACTIVE cycle without termination.
  - At tmo_cnt==TIMEOUT-1: assert wbm_err_o and timeout_o for one cycle. Slave cyc/stb go low in the same cycle, then IDLE.
- Simultaneous slave ack and watchdog expiry: ack wins; no err and no timeout_o.
- Multiple slave terminations asserted together: all are forwarded; the slave is at fault.
- Reset (async, any state): state=IDLE, sel_idx=0, tmo_cnt=0.
  - All wbs_cyc_o, wbs_stb_o and wbs_we_o are 0.
  - wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o and wbm_dat_o are 0.

## Timing
- Decode latency is 1 cycle: master stb in cycle 0 gives slave stb in cycle 1.
- Termination is combinational: slave ack in cycle k gives wbm_ack_o in cycle k.
- Minimum transfer is 2 cycles for a zero-wait-state slave, plus one IDLE cycle before the next decode.
- Decode error: stb in cycle 0, err in cycle 1, IDLE in cycle 2.
- Watchdog error occurs TIMEOUT cycles after ACTIVE entry.

## Configuration
- WB_MUX_TIMEOUT_EN defined: watchdog, tmo_cnt and timeout_o are active as described.
- WB_MUX_TIMEOUT_EN undefined: no counter is synthesised and timeout_o is tied 0. ACTIVE waits indefinitely for termination or master abort.

## Structure
- Package wb_mux_pkg holds:
  - state encoding localparams (IDLE=2'd0, ACTIVE=2'd1, ERR=2'd2);
  - a clog2 function for the sel_idx and tmo_cnt widths;
  - the PORTS maximum constant.
- Sub-module wb_addr_decode (combinational): takes the address and the flattened addr/msk. It outputs a one-hot match vector, a match_valid flag and the priority index.

## Test plan
- PORTS=4, slave 2 at 0x2000_0000 with mask 0xF000_0000. Read at 0x2000_0010 with slave ack in cycle 3 -> wbs_stb_o=4'b0100 in cycles 1..3; wbm_ack_o and data in cycle 3; IDLE in cycle 4.
- Slaves 0 and 1 both match 0x0000_0100 -> only wbs_cyc_o[0] asserts.
- Address 0xF000_0000 matches no slave -> wbm_err_o=1 in cycle 1 only; no wbs_stb_o asserts.
- TIMEOUT=16 with a silent slave -> wbm_err_o and timeout_o in cycle 16, strobes drop. With the macro undefined, strobes are still high at cycle 100.
- Unselected slave 3 asserts ack during a transfer to slave 1 -> wbm_ack_o stays 0.
- rst asserted mid-ACTIVE -> all slave strobes and master terminations are 0 immediately; the next request decodes normally.
